// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard/sequencing controller:
// register-id sentinel, FSM state encodings and PC-select codes.
package hazard_pkg;

    localparam logic [3:0] NOREG = 4'b1111;

    typedef enum logic [1:0] {
        RUN       = 2'b00,
        MEMSTALL  = 2'b01,
        EXC_DRAIN = 2'b10,
        EXC_JUMP  = 2'b11
    } state_t;

    localparam logic [1:0] PC_SEL_SEQ = 2'b00;
    localparam logic [1:0] PC_SEL_BR  = 2'b01;
    localparam logic [1:0] PC_SEL_EXC = 2'b10;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-facing signal bundle of the hazard controller; the controller
// takes the slave side, the pipeline (or a bench) drives the master side.
interface hazard_ctrl_if;
    logic [3:0]  id_regsrc1_i;
    logic [3:0]  id_regsrc2_i;
    logic        ex_memread_i;
    logic [3:0]  ex_regdst_i;
    logic        branch_taken_i;
    logic        mem_access_i;
    logic        exc_req_i;
    logic [15:0] epc_i;
    logic        pc_stall_o;
    logic        if_id_stall_o;
    logic        flush_if_o;
    logic        flush_id_o;
    logic [1:0]  pc_sel_o;
    logic [15:0] epc_o;
    logic [1:0]  state_o;

    modport master (
        output id_regsrc1_i, id_regsrc2_i, ex_memread_i, ex_regdst_i,
               branch_taken_i, mem_access_i, exc_req_i, epc_i,
        input  pc_stall_o, if_id_stall_o, flush_if_o, flush_id_o,
               pc_sel_o, epc_o, state_o
    );

    modport slave (
        input  id_regsrc1_i, id_regsrc2_i, ex_memread_i, ex_regdst_i,
               branch_taken_i, mem_access_i, exc_req_i, epc_i,
        output pc_stall_o, if_id_stall_o, flush_if_o, flush_id_o,
               pc_sel_o, epc_o, state_o
    );
endinterface

// File: rtl/hazard_ctrl_ld_use_detect.sv
// Combinational load-use detector: a load in EX whose destination feeds
// either source of the instruction in ID.
module ld_use_detect
    import hazard_pkg::*;
(
    input  logic       ex_memread,
    input  logic [3:0] ex_regdst,
    input  logic [3:0] id_regsrc1,
    input  logic [3:0] id_regsrc2,
    output logic       lu
);
    assign lu = ex_memread && (ex_regdst != NOREG) &&
                ((ex_regdst == id_regsrc1) || (ex_regdst == id_regsrc2));
endmodule

// File: rtl/hazard_ctrl.sv
// Prioritised stall/flush source for the five-stage pipeline: structural
// memory stalls, exception drain-and-vector, load-use bubbles and branches.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_WAIT = 1,
    parameter int DRAIN    = 2
)(
    input logic         CLK,
    input logic         RST,
    hazard_ctrl_if.slave hz
);
    localparam logic [2:0] MEM_CNT   = 3'(MEM_WAIT - 1);
    localparam logic [2:0] DRAIN_CNT = 3'(DRAIN - 1);

    state_t      state_reg;
    logic [2:0]  cnt_reg;
    logic        exc_pend_reg;
    logic [15:0] epc_reg;
    logic        lu;
    logic        exc;

    ld_use_detect u_ld_use (
        .ex_memread (hz.ex_memread_i),
        .ex_regdst  (hz.ex_regdst_i),
        .id_regsrc1 (hz.id_regsrc1_i),
        .id_regsrc2 (hz.id_regsrc2_i),
        .lu         (lu)
    );

    assign exc        = hz.exc_req_i || exc_pend_reg;
    assign hz.epc_o   = epc_reg;
    assign hz.state_o = state_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= RUN;
            cnt_reg      <= 3'd0;
            exc_pend_reg <= 1'b0;
            epc_reg      <= 16'h0000;
        end else begin
            case (state_reg)
                RUN: begin
                    if (hz.mem_access_i) begin
                        // A request colliding with a memory stall is parked; first EPC wins.
                        if (hz.exc_req_i && !exc_pend_reg) begin
                            exc_pend_reg <= 1'b1;
                            epc_reg      <= hz.epc_i;
                        end
                        if (MEM_WAIT > 1) begin
                            state_reg <= MEMSTALL;
                            cnt_reg   <= MEM_CNT;
                        end
                    end else if (exc) begin
                        if (!exc_pend_reg)
                            epc_reg <= hz.epc_i;
                        exc_pend_reg <= 1'b0;
                        cnt_reg      <= DRAIN_CNT;
                        state_reg    <= (DRAIN == 1) ? EXC_JUMP : EXC_DRAIN;
                    end
                end
                MEMSTALL: begin
                    if (hz.exc_req_i && !exc_pend_reg) begin
                        exc_pend_reg <= 1'b1;
                        epc_reg      <= hz.epc_i;
                    end
                    cnt_reg <= cnt_reg - 3'd1;
                    if (cnt_reg <= 3'd1)
                        state_reg <= RUN;
                end
                EXC_DRAIN: begin
                    cnt_reg <= cnt_reg - 3'd1;
                    if (cnt_reg <= 3'd1)
                        state_reg <= EXC_JUMP;
                end
                EXC_JUMP: state_reg <= RUN;
                default:  state_reg <= RUN;
            endcase
        end
    end

    always_comb begin
        hz.pc_stall_o    = 1'b0;
        hz.if_id_stall_o = 1'b0;
        hz.flush_if_o    = 1'b0;
        hz.flush_id_o    = 1'b0;
        hz.pc_sel_o      = PC_SEL_SEQ;
        if (!RST) begin
            case (state_reg)
                RUN: begin
                    if (hz.mem_access_i) begin
                        hz.pc_stall_o = 1'b1;
                        hz.flush_if_o = 1'b1;
                    end else if (exc) begin
                        hz.pc_stall_o = 1'b1;
                        hz.flush_if_o = 1'b1;
                        hz.flush_id_o = 1'b1;
                    end else if (lu) begin
                        hz.pc_stall_o    = 1'b1;
                        hz.if_id_stall_o = 1'b1;
                        hz.flush_id_o    = 1'b1;
                    end else if (hz.branch_taken_i) begin
                        hz.pc_sel_o   = PC_SEL_BR;
                        hz.flush_if_o = 1'b1;
                    end
                end
                MEMSTALL: begin
                    hz.pc_stall_o = 1'b1;
                    hz.flush_if_o = 1'b1;
                end
                EXC_DRAIN: begin
                    hz.pc_stall_o = 1'b1;
                    hz.flush_if_o = 1'b1;
                    hz.flush_id_o = 1'b1;
                end
                EXC_JUMP: begin
                    hz.pc_sel_o   = PC_SEL_EXC;
                    hz.flush_if_o = 1'b1;
                    hz.flush_id_o = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 16-bit five-stage CPU. It drives the PC, the IF/ID register and the flush_id_i input of the ID/EX register.
- Detects load-use hazards, taken branches, and shared-memory structural conflicts (a MEM-stage access to instruction RAM blocks fetch).
- Sequences exception entry: drain the pipeline, then redirect to the vector.
- Central, prioritised source of all stall and flush strobes.

Parameters:
NOREG, 4'b1111, register id meaning "no register"; never matches as a hazard.
MEM_WAIT, 1, total cycles fetch is blocked per shared-memory access (legal 1..7).
DRAIN, 2, bubble cycles inserted before the exception redirect (legal 1..3).

Ports:
CLK  in  1  system clock, rising edge.
RST  in  1  synchronous reset, active-high.
id_regsrc1_i  in  4  source register 1 of the instruction in ID.
id_regsrc2_i  in  4  source register 2 of the instruction in ID.
ex_memread_i  in  1  memread output of ID/EX.
ex_regdst_i  in  4  regdst output of ID/EX.
branch_taken_i  in  1  branch in ID resolved taken.
mem_access_i  in  1  MEM stage is using the instruction RAM this cycle.
exc_req_i  in  1  exception or soft-interrupt request from ID.
epc_i  in  16  PC of the excepting instruction.
pc_stall_o  out  1  hold the PC.
if_id_stall_o  out  1  hold the IF/ID register.
flush_if_o  out  1  load a NOP into IF/ID.
flush_id_o  out  1  bubble into ID/EX; connects to flush_id_i.
pc_sel_o  out  2  00 sequential, 01 branch target, 10 exception vector.
epc_o  out  16  latched exception PC.
state_o  out  2  FSM state, for debug.

Behaviour:
- States: RUN=00, MEMSTALL=01, EXC_DRAIN=10, EXC_JUMP=11. Registers: state, 3-bit cnt, exc_pend, epc.
- Reset: at any edge with RST=1 the block enters RUN, cnt=0, exc_pend=0, epc_o=0.
  - While RST=1, all strobe outputs are 0 and pc_sel_o=00.
  - Reset mid-sequence aborts it; nothing resumes.
- Hazard terms, combinational:
  - lu = ex_memread_i && ex_regdst_i!=NOREG && (ex_regdst_i==id_regsrc1_i || ex_regdst_i==id_regsrc2_i).
  - exc = exc_req_i || exc_pend.
- RUN, evaluated in priority order; only the highest-priority event acts:
  1. mem_access_i: pc_stall_o=1, flush_if_o=1. If MEM_WAIT>1, go to MEMSTALL with cnt=MEM_WAIT-1.
  2. exc: epc_o<=epc_i unless exc_pend is already set. Assert flush_if_o=1, flush_id_o=1, pc_stall_o=1. Go to EXC_DRAIN with cnt=DRAIN-1, or to EXC_JUMP if DRAIN=1. Clear exc_pend.
  3. lu: pc_stall_o=1, if_id_stall_o=1, flush_id_o=1 for exactly that cycle. Any branch_taken_i in the same cycle is ignored; it is re-evaluated next cycle.
  4. branch_taken_i: pc_sel_o=01, flush_if_o=1.
  5. Otherwise all strobes are 0 and pc_sel_o=00.
- Exception deferral: if exc_req_i arrives while event 1 wins, or while in MEMSTALL, the block sets exc_pend and latches epc_i on that first cycle. Later epc_i values are ignored until the exception is accepted.
- MEMSTALL:
  - Outputs: pc_stall_o=1, flush_if_o=1.
  - cnt decrements each cycle. When cnt reaches 0 the block returns to RUN; a pending exception is taken there.
- EXC_DRAIN:
  - Outputs: pc_stall_o=1, flush_if_o=1, flush_id_o=1.
  - cnt decrements; at cnt=0 go to EXC_JUMP.
- EXC_JUMP:
  - Outputs: pc_sel_o=10, flush_if_o=1, flush_id_o=1, pc_stall_o=0.
  - Next state is RUN.
- exc_req_i is ignored in EXC_DRAIN and EXC_JUMP, and exc_pend is not set there.
- if_id_stall_o is asserted only by the load-use event.
- All strobe outputs are combinational from state and inputs. epc_o and state_o are registered.

Decomposition:
- Package hazard_pkg holds NOREG, the state encodings and the PC_SEL_SEQ/BR/EXC codes.
- Sub-module ld_use_detect, purely combinational, computes lu from the four register-id inputs.

Test Plan:
- Load-use:
  - Stimulus: ex_memread_i=1, ex_regdst_i=4'h3, id_regsrc2_i=4'h3, branch_taken_i=1.
  - Response: one cycle of pc_stall_o=if_id_stall_o=flush_id_o=1 with pc_sel_o=00. Next cycle ex_memread_i=0, so the branch acts: pc_sel_o=01, flush_if_o=1.
- NOREG and no-load:
  - Stimulus: ex_regdst_i=id_regsrc1_i=4'hF with ex_memread_i=1; then ex_memread_i=0 with ex_regdst_i=id_regsrc1_i=4'h3.
  - Response: no stall in either case.
- Structural, MEM_WAIT=3:
  - Stimulus: mem_access_i pulse.
  - Response: pc_stall_o=flush_if_o=1 for exactly 3 cycles, state_o 00→01→01→00.
- Exception, DRAIN=2:
  - Stimulus: exc_req_i with epc_i=16'h0042.
  - Response: epc_o=16'h0042 from the next cycle. Exactly 2 cycles of flush_id_o=flush_if_o=pc_stall_o=1 (accept cycle plus one EXC_DRAIN cycle), then one cycle of pc_sel_o=10, then RUN.
- Deferral:
  - Stimulus: exc_req_i with epc_i=16'h0100 during MEMSTALL, epc_i changes to 16'h0200 afterwards, exc_req_i dropped.
  - Response: the exception is still taken after MEMSTALL, and epc_o=16'h0100.
- Reset:
  - Stimulus: RST=1 in EXC_DRAIN.
  - Response: next cycle state_o=00, epc_o=0, all strobes 0, and no vector jump.
